// File: rtl/mips_div_pkg.sv
// Shared divider defines: FSM encoding, iteration count
// and the DIV/DIVU ALU control codes.
package mips_div_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } divState_t;

endpackage

// File: rtl/mips_div_if.sv
// Divide-start handshake between the execute stage
// (master) and the divider (slave).
interface mips_div_if;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output start_i, signed_i, opdata1_i,
        output opdata2_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i,
        input  opdata2_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/mips_div_step.sv
// One restoring radix-2 iteration on the 65-bit
// {partial remainder, quotient} register.
module div_step (
    input  logic [64:0] work,
    input  logic [31:0] divisor,
    output logic [64:0] workOut
);
    logic [64:0] sh;
    logic [32:0] diff;

    assign sh   = work << 1;
    assign diff = sh[64:32] - {1'b0, divisor};

    // Sign bit of the 33-bit trial difference decides restore.
    assign workOut = diff[32] ? sh
                              : {diff, sh[31:0] | 32'd1};
endmodule

// File: rtl/mips_div.sv
// Multi-cycle 32-bit divider: FSM, sign handling, counter.
// Result is {remainder, quotient} with a one-cycle ready.
module mips_div
    import mips_div_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    mips_div_if.slave  div
);
    divState_t   state, stateNxt;
    logic [5:0]  cnt, cntNxt;
    logic [64:0] work, workNxt, stepOut;
    logic [31:0] dvsr, dvsrNxt;
    logic        negQuo, negQuoNxt;
    logic        negRem, negRemNxt;
    logic [63:0] result, resultNxt;
    logic        ready, readyNxt;
    logic [31:0] mag1, mag2, quo, rem;

    assign mag1 = (div.signed_i && div.opdata1_i[31])
                ? -div.opdata1_i : div.opdata1_i;
    assign mag2 = (div.signed_i && div.opdata2_i[31])
                ? -div.opdata2_i : div.opdata2_i;

    div_step u_step (
        .work    (work),
        .divisor (dvsr),
        .workOut (stepOut)
    );

    assign quo = negQuo ? -stepOut[31:0]  : stepOut[31:0];
    assign rem = negRem ? -stepOut[63:32] : stepOut[63:32];

    always_comb begin
        stateNxt  = state;
        cntNxt    = cnt;
        workNxt   = work;
        dvsrNxt   = dvsr;
        negQuoNxt = negQuo;
        negRemNxt = negRem;
        resultNxt = result;
        readyNxt  = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (div.start_i && !div.annul_i) begin
                    workNxt   = {33'b0, mag1};
                    dvsrNxt   = mag2;
                    cntNxt    = 6'd0;
                    negQuoNxt = div.signed_i &
                        (div.opdata1_i[31] ^ div.opdata2_i[31]);
                    negRemNxt = div.signed_i & div.opdata1_i[31];
                    stateNxt  = (div.opdata2_i == 32'd0)
                              ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ZERO: begin
                if (div.annul_i) begin
                    stateNxt = DIV_IDLE;
                end else begin
                    stateNxt  = DIV_END;
                    resultNxt = 64'h0;
                    readyNxt  = 1'b1;
                end
            end
            DIV_ON: begin
                if (div.annul_i) begin
                    stateNxt = DIV_IDLE;
                end else begin
                    workNxt = stepOut;
                    cntNxt  = cnt + 6'd1;
                    // Last iteration: correct signs and deliver.
                    if (cnt == 6'(DIV_ITER - 1)) begin
                        stateNxt  = DIV_END;
                        resultNxt = {rem, quo};
                        readyNxt  = 1'b1;
                    end
                end
            end
            DIV_END:  stateNxt = DIV_IDLE;
            default:  stateNxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= DIV_IDLE;
            cnt    <= 6'd0;
            work   <= 65'd0;
            dvsr   <= 32'd0;
            negQuo <= 1'b0;
            negRem <= 1'b0;
            result <= 64'h0;
            ready  <= 1'b0;
        end else begin
            state  <= stateNxt;
            cnt    <= cntNxt;
            work   <= workNxt;
            dvsr   <= dvsrNxt;
            negQuo <= negQuoNxt;
            negRem <= negRemNxt;
            result <= resultNxt;
            ready  <= readyNxt;
        end
    end

    assign div.result_o = result;
    assign div.ready_o  = ready;
endmodule

// File: tb/tb_mips_div.sv
// Directed bench for mips_div: latency, pulse width,
// signed corners, divide-by-zero, annul and reset.
module tb_mips_div;
    logic clk;
    logic resetn;
    int   tests;
    int   fails;

    mips_div_if dif ();

    mips_div dut (
        .clk    (clk),
        .resetn (resetn),
        .div    (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic launch(input logic s,
                          input logic [31:0] a,
                          input logic [31:0] b);
        dif.signed_i  = s;
        dif.opdata1_i = a;
        dif.opdata2_i = b;
        dif.start_i   = 1'b1;
        @(posedge clk); #1;
        dif.start_i   = 1'b0;
    endtask

    task automatic wait_ready(input int budget,
                              output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (dif.ready_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        tests++;
        if (dif.ready_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready got %b want 0",
                     dif.ready_o);
        end
        tests++;
        if (dif.result_o !== 64'h0) begin
            fails++;
            $display("FAIL reset_result got %h want 0",
                     dif.result_o);
        end
    endtask

    task automatic test_one(input string nm,
                            input logic s,
                            input logic [31:0] a,
                            input logic [31:0] b,
                            input logic [63:0] exp);
        int lat;
        launch(s, a, b);
        wait_ready(40, lat);
        tests++;
        if (lat !== 32) begin
            fails++;
            $display("FAIL %s_latency got %0d want 32",
                     nm, lat);
        end
        tests++;
        if (dif.result_o !== exp) begin
            fails++;
            $display("FAIL %s_result got %h want %h",
                     nm, dif.result_o, exp);
        end
        @(posedge clk); #1;
        tests++;
        if (dif.ready_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_pulse got %b want 0",
                     nm, dif.ready_o);
        end
    endtask

    task automatic test_unsigned;
        test_one("u100_7", 1'b0, 32'd100, 32'd7,
                 {32'd2, 32'd14});
        test_one("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
                 {32'd0, 32'hFFFF_FFFF});
    endtask

    task automatic test_signed;
        test_one("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                 {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        test_one("smin_m1", 1'b1, 32'h8000_0000,
                 32'hFFFF_FFFF,
                 {32'h0, 32'h8000_0000});
    endtask

    task automatic test_divzero;
        int lat;
        launch(1'b0, 32'd5, 32'd0);
        wait_ready(5, lat);
        tests++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL dz_latency got %0d want 1", lat);
        end
        tests++;
        if (dif.result_o !== 64'h0) begin
            fails++;
            $display("FAIL dz_result got %h want 0",
                     dif.result_o);
        end
        @(posedge clk); #1;
        tests++;
        if (dif.ready_o !== 1'b0) begin
            fails++;
            $display("FAIL dz_pulse got %b want 0",
                     dif.ready_o);
        end
    endtask

    task automatic test_annul_b2b;
        int lat;
        int seen;
        logic [63:0] prev;
        test_one("pre", 1'b0, 32'd100, 32'd7,
                 {32'd2, 32'd14});
        prev = dif.result_o;
        seen = 0;
        launch(1'b0, 32'd1000, 32'd3);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (dif.ready_o) seen++;
        end
        dif.annul_i = 1'b1;
        @(posedge clk); #1;
        dif.annul_i   = 1'b0;
        dif.signed_i  = 1'b0;
        dif.opdata1_i = 32'd9;
        dif.opdata2_i = 32'd3;
        dif.start_i   = 1'b1;
        @(posedge clk); #1;
        if (dif.ready_o) seen++;
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL annul_pulse got %0d want 0", seen);
        end
        tests++;
        if (dif.result_o !== prev) begin
            fails++;
            $display("FAIL annul_hold got %h want %h",
                     dif.result_o, prev);
        end
        dif.opdata1_i = 32'hDEAD_BEEF;
        dif.opdata2_i = 32'd5;
        wait_ready(40, lat);
        dif.start_i = 1'b0;
        tests++;
        if (lat !== 32) begin
            fails++;
            $display("FAIL hold_latency got %0d want 32",
                     lat);
        end
        tests++;
        if (dif.result_o !== {32'd0, 32'd3}) begin
            fails++;
            $display("FAIL d9_3 got %h want %h",
                     dif.result_o, {32'd0, 32'd3});
        end
        @(posedge clk); #1;
        tests++;
        if (dif.ready_o !== 1'b0) begin
            fails++;
            $display("FAIL d9_3_pulse got %b want 0",
                     dif.ready_o);
        end
        test_one("b2b", 1'b1, 32'hFFFF_FFEC, 32'd3,
                 {32'hFFFF_FFFE, 32'hFFFF_FFFA});
    endtask

    task automatic test_reset_mid;
        launch(1'b0, 32'd100, 32'd7);
        repeat (15) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        test_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        test_one("post_rst", 1'b0, 32'd100, 32'd7,
                 {32'd2, 32'd14});
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        resetn        = 1'b0;
        dif.start_i   = 1'b0;
        dif.signed_i  = 1'b0;
        dif.opdata1_i = 32'd0;
        dif.opdata2_i = 32'd0;
        dif.annul_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        resetn = 1'b1;
        @(posedge clk); #1;
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul_b2b();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end
endmodule
